openhw_cachelinebus: RTL



---
 rtl/openhw_cachelinebus.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/openhw_cachelinebus.sv
// Bus-side line sequencer for one cache: serializes dirty victim lines into
// write beats and assembles read beats into a fill line for the selected way.
module openhw_cachelinebus #(
  parameter int unsigned PA_BITS   = 34,
  parameter int unsigned LINELEN   = 256,
  parameter int unsigned BEATW     = 64,
  parameter int unsigned OFFSETLEN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FetchReq,
  input  logic               WritebackReq,
  input  logic               FlushStage,
  input  logic [PA_BITS-1:0] FetchAdr,
  input  logic [PA_BITS-1:0] VictimAdr,
  input  logic [LINELEN-1:0] VictimLine,
  input  logic               BusReady,
  input  logic [BEATW-1:0]   BusRData,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [BEATW-1:0]   BusWData,
  output logic [LINELEN-1:0] LineWriteData,
  output logic               SetValid,
  output logic               ClearDirty,
  output logic               Busy
);

  localparam int unsigned BEATS      = LINELEN / BEATW;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEAT_BYTES = BEATW / 8;
  localparam logic [PA_BITS-1:0] ADR_MASK = ~((PA_BITS'(1) << OFFSETLEN) - PA_BITS'(1));
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    WBDONE    = 3'd2,
    FETCH     = 3'd3,
    FILLDONE  = 3'd4
  } state_t;

  state_t               state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic                 pendFill, pendFillNext;
  logic [PA_BITS-1:0]   wbBase, wbBaseNext;
  logic [PA_BITS-1:0]   fillBase, fillBaseNext;
  logic [LINELEN-1:0]   victim, victimNext;
  logic [LINELEN-1:0]   lineNext;
  logic [PA_BITS-1:0]   burstBase;
  logic                 busReqNext;
  logic                 busWriteNext;
  logic [PA_BITS-1:0]   busAdrNext;
  logic [BEATW-1:0]     busWDataNext;

  // Next-state, datapath and next-output decode; outputs are registered from these
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    pendFillNext = pendFill;
    wbBaseNext   = wbBase;
    fillBaseNext = fillBase;
    victimNext   = victim;
    lineNext     = LineWriteData;

    case (state)
      IDLE: begin
        if (!FlushStage) begin
          if (WritebackReq) begin
            stateNext    = WRITEBACK;
            wbBaseNext   = VictimAdr & ADR_MASK;
            victimNext   = VictimLine;
            pendFillNext = FetchReq;
            fillBaseNext = FetchAdr & ADR_MASK;
            cntNext      = '0;
          end else if (FetchReq) begin
            stateNext    = FETCH;
            pendFillNext = 1'b0;
            fillBaseNext = FetchAdr & ADR_MASK;
            cntNext      = '0;
          end
        end
      end
      WRITEBACK: begin
        if (BusReady) begin
          if (cnt == LAST_CNT) begin
            cntNext   = '0;
            stateNext = WBDONE;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
      end
      WBDONE: begin
        stateNext    = pendFill ? FETCH : IDLE;
        pendFillNext = 1'b0;
        cntNext      = '0;
      end
      FETCH: begin
        if (BusReady) begin
          lineNext[BEATW*int'(cnt) +: BEATW] = BusRData;
          if (cnt == LAST_CNT) begin
            cntNext   = '0;
            stateNext = FILLDONE;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
      end
      FILLDONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    burstBase    = (stateNext == WRITEBACK) ? wbBaseNext : fillBaseNext;
    busReqNext   = (stateNext == WRITEBACK) || (stateNext == FETCH);
    busWriteNext = (stateNext == WRITEBACK);
    busAdrNext   = busReqNext ? (burstBase + PA_BITS'(cntNext) * PA_BITS'(BEAT_BYTES)) : '0;
    busWDataNext = busWriteNext ? victimNext[BEATW*int'(cntNext) +: BEATW] : '0;
  end

  // State, capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pendFill      <= 1'b0;
      wbBase        <= '0;
      fillBase      <= '0;
      victim        <= '0;
      LineWriteData <= '0;
      BusReq        <= 1'b0;
      BusWrite      <= 1'b0;
      BusAdr        <= '0;
      BusWData      <= '0;
      SetValid      <= 1'b0;
      ClearDirty    <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      pendFill      <= pendFillNext;
      wbBase        <= wbBaseNext;
      fillBase      <= fillBaseNext;
      victim        <= victimNext;
      LineWriteData <= lineNext;
      BusReq        <= busReqNext;
      BusWrite      <= busWriteNext;
      BusAdr        <= busAdrNext;
      BusWData      <= busWDataNext;
      SetValid      <= (stateNext == FILLDONE);
      ClearDirty    <= (stateNext == WBDONE);
      Busy          <= (stateNext != IDLE);
    end
  end

endmodule
